// File: rtl/line_window_buffer.sv
// Single-line pixel buffer that fills one line, then emits KSIZE-pixel windows read in order.
// Define LINE_WINDOW_BUFFER_EDGE_REPLICATE_EN to replicate the last pixel into slots past the line end (default: zero padding).
module line_window_buffer #(
  parameter int PIX_W    = 8,
  parameter int LINE_LEN = 512,
  parameter int KSIZE    = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_clear,
  input  logic                     i_wr_valid,
  input  logic [PIX_W-1:0]         i_wr_data,
  output logic                     o_wr_ready,
  input  logic                     i_rd_en,
  output logic [KSIZE*PIX_W-1:0]   o_window,
  output logic                     o_rd_valid,
  output logic                     o_line_full
);

  localparam int AW = $clog2(LINE_LEN);
  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nx_s;
  logic [AW-1:0]           wp_r;
  logic [AW-1:0]           rp_r;
  logic                    wr_fire_s;
  logic                    rd_fire_s;
  logic [PIX_W-1:0]        mem_r [LINE_LEN];
  logic [PIX_W-1:0]        oor_s;
  logic [AW:0]             idx_s;
  logic [KSIZE*PIX_W-1:0]  window_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and operation strobes; clear overrides everything
  always_comb begin
    state_nx_s = state_r;
    wr_fire_s  = 1'b0;
    rd_fire_s  = 1'b0;
    case (state_r)
      EMPTY, FILL: begin
        if (i_wr_valid) begin
          wr_fire_s  = 1'b1;
          state_nx_s = (wp_r == LAST) ? FULL : FILL;
        end else begin
          state_nx_s = state_r;
        end
      end
      FULL: begin
        if (i_rd_en) begin
          rd_fire_s  = 1'b1;
          state_nx_s = (rp_r == LAST) ? EMPTY : FULL;
        end else begin
          state_nx_s = FULL;
        end
      end
      default: state_nx_s = EMPTY;
    endcase
    if (i_clear) begin
      state_nx_s = EMPTY;
      wr_fire_s  = 1'b0;
      rd_fire_s  = 1'b0;
    end else begin
      state_nx_s = state_nx_s;
    end
  end

  // Pointers; wp wraps naturally to 0 on the last write, rp on the last read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_r <= '0;
      rp_r <= '0;
    end else if (i_clear) begin
      wp_r <= '0;
      rp_r <= '0;
    end else begin
      if (wr_fire_s) wp_r <= wp_r + {{(AW-1){1'b0}}, 1'b1};
      if (rd_fire_s) rp_r <= rp_r + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  // Pixel storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_fire_s) mem_r[wp_r] <= i_wr_data;
  end

`ifdef LINE_WINDOW_BUFFER_EDGE_REPLICATE_EN
  assign oor_s = mem_r[LAST];
`else
  assign oor_s = {PIX_W{1'b0}};
`endif

  // Window gather; slots beyond the line end take the padding value
  always_comb begin
    window_s = '0;
    idx_s    = '0;
    for (int k = 0; k < KSIZE; k++) begin
      idx_s = {1'b0, rp_r} + (AW+1)'(k);
      if (idx_s > {1'b0, LAST}) begin
        window_s[k*PIX_W +: PIX_W] = oor_s;
      end else begin
        window_s[k*PIX_W +: PIX_W] = mem_r[idx_s[AW-1:0]];
      end
    end
  end

  // Registered read outputs; o_window holds between reads and across clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_window   <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= rd_fire_s;
      if (rd_fire_s) o_window <= window_s;
    end
  end

  assign o_wr_ready  = (state_r != FULL);
  assign o_line_full = (state_r == FULL);

endmodule

// File: tb/tb_line_window_buffer.sv
// Randomized scoreboard bench for line_window_buffer (PIX_W=8, LINE_LEN=8, KSIZE=3).
module tb_line_window_buffer;
  localparam int PW = 8;
  localparam int LL = 8;
  localparam int KS = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_clear;
  logic              i_wr_valid;
  logic [PW-1:0]     i_wr_data;
  logic              o_wr_ready;
  logic              i_rd_en;
  logic [KS*PW-1:0]  o_window;
  logic              o_rd_valid;
  logic              o_line_full;

  line_window_buffer #(.PIX_W(PW), .LINE_LEN(LL), .KSIZE(KS)) dut (
    .clk(clk), .reset_n(reset_n), .i_clear(i_clear),
    .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
    .i_rd_en(i_rd_en), .o_window(o_window), .o_rd_valid(o_rd_valid),
    .o_line_full(o_line_full)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a line of pixels, how many are stored, and the next window start
  logic [PW-1:0]    line_m [LL];
  int               filled = 0;
  int               rdp = 0;
  logic [KS*PW-1:0] sbq [$];
  logic [KS*PW-1:0] last_win = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [KS*PW-1:0] model_window(input int start);
    logic [KS*PW-1:0] w;
    logic [PW-1:0] pad;
    w = '0;
`ifdef LINE_WINDOW_BUFFER_EDGE_REPLICATE_EN
    pad = line_m[LL-1];
`else
    pad = 8'h00;
`endif
    for (int k = 0; k < KS; k++) begin
      w[k*PW +: PW] = (start + k < LL) ? line_m[start + k] : pad;
    end
    return w;
  endfunction

  // One clock of stimulus; the model is advanced to the state after the coming edge
  task automatic cyc(input logic wv, input logic [PW-1:0] wd, input logic rd, input logic clr);
    i_wr_valid = wv;
    i_wr_data  = wd;
    i_rd_en    = rd;
    i_clear    = clr;
    if (clr) begin
      filled = 0;
      rdp    = 0;
    end else if (filled < LL) begin
      if (wv) begin
        line_m[filled] = wd;
        filled++;
      end
    end else if (rd) begin
      sbq.push_back(model_window(rdp));
      rdp++;
      if (rdp == LL) begin
        filled = 0;
        rdp    = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("wr_ready", {31'd0, o_wr_ready}, {31'd0, filled < LL});
    chk("line_full", {31'd0, o_line_full}, {31'd0, filled == LL});
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_window"}, {8'd0, o_window}, 32'd0);
    chk({tag, "_rd_valid"}, {31'd0, o_rd_valid}, 32'd0);
    chk({tag, "_wr_ready"}, {31'd0, o_wr_ready}, 32'd1);
    chk({tag, "_line_full"}, {31'd0, o_line_full}, 32'd0);
  endtask

  // Monitor: pop expected window on every valid, otherwise o_window must hold
  always @(negedge clk) begin
    if (!reset_n) begin
      last_win = '0;
      sbq.delete();
    end else if (o_rd_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rd_valid", {31'd0, o_rd_valid}, 32'd0);
      end else begin
        last_win = sbq.pop_front();
        chk("window", {8'd0, o_window}, {8'd0, last_win});
      end
    end else begin
      chk("window_hold", {8'd0, o_window}, {8'd0, last_win});
    end
  end

  initial begin
    reset_n = 1'b0; i_clear = 1'b0; i_wr_valid = 1'b0; i_wr_data = '0; i_rd_en = 1'b0;
    for (int i = 0; i < LL; i++) line_m[i] = '0;
    #12;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Fill 0x10..0x17, then a 9th write that must be ignored
    for (int i = 0; i < LL; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    chk("full_after_8", {31'd0, o_line_full}, 32'd1);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);

    // Eight back-to-back reads with spot checks on known windows
    for (int i = 0; i < LL; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rd_valid_latency", {31'd0, o_rd_valid}, 32'd1);
      if (i == 0) chk("first_window", {8'd0, o_window}, 32'h00121110);
      if (i == 3) chk("fourth_window", {8'd0, o_window}, 32'h00151413);
`ifdef LINE_WINDOW_BUFFER_EDGE_REPLICATE_EN
      if (i == 6) chk("read7_window", {8'd0, o_window}, 32'h00171716);
      if (i == 7) chk("read8_window", {8'd0, o_window}, 32'h00171717);
`else
      if (i == 6) chk("read7_window", {8'd0, o_window}, 32'h00001716);
      if (i == 7) chk("read8_window", {8'd0, o_window}, 32'h00000017);
`endif
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("no_read_in_empty", {31'd0, o_rd_valid}, 32'd0);

    // Clear after five writes, then a fresh line must start at wp=0
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("clear_rd_valid", {31'd0, o_rd_valid}, 32'd0);
    for (int i = 0; i < LL; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
    cyc(1'b1, 8'hBB, 1'b1, 1'b0);
    chk("after_clear_window", {8'd0, o_window}, 32'h00222120);

    // Two more reads (rp=3), idle, then asynchronous reset between edges
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sbq.delete();
    last_win = '0;
    filled = 0;
    rdp = 0;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0);
    for (int i = 3; i < LL; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_reset_window", {8'd0, o_window}, 32'h00323130);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 64) == 0);
    end
    idle();
    idle();
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
